// File: rtl/async_fifo_v2.sv
// Dual-clock FIFO: gray-pointer crossing, registered levels and flags.
// Define ASYNC_FIFO_V2_FWFT_EN for a first-word-fall-through read port.
module async_fifo_v2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 6,
    parameter int SYNC_STAGES   = 2,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH-4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LAST  = SYNC_STAGES - 1;
    localparam logic [ADDR_WIDTH:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_T = PW'(AEMPTY_THRESH);
    localparam logic AF_RST = (AFULL_THRESH <= 0);

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
    logic [ADDR_WIDTH:0] rd_gray_sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0] rd_gray_sync_d [SYNC_STAGES];
    logic [ADDR_WIDTH:0] rd_bin_sync, wr_level_q, wr_level_d, full_cmp;
    logic                full_q, full_d, afull_q, afull_d;
    logic                overflow_q, overflow_d, wr_push;

    logic [ADDR_WIDTH:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
    logic [ADDR_WIDTH:0] wr_gray_sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0] wr_gray_sync_d [SYNC_STAGES];
    logic [ADDR_WIDTH:0] wr_bin_sync, rd_level_q, rd_level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d, arr_empty_q, arr_empty_d;
    logic                aempty_q, aempty_d, underflow_q, underflow_d;
    logic                rd_fetch;
`ifdef ASYNC_FIFO_V2_FWFT_EN
    logic                rd_pop;
`endif

    always_comb begin
        wr_push = wr_en && !full_q;
        wr_bin_d = wr_bin_q + PW'(wr_push);
        wr_gray_d = bin2gray(wr_bin_d);
        rd_gray_sync_d[0] = rd_gray_q;
        for (int i = 1; i < SYNC_STAGES; i++) rd_gray_sync_d[i] = rd_gray_sync_q[i-1];
        rd_bin_sync = gray2bin(rd_gray_sync_q[LAST]);
        // Full when the writer is exactly one lap ahead of the reader.
        full_cmp = {~rd_gray_sync_q[LAST][ADDR_WIDTH:ADDR_WIDTH-1],
                    rd_gray_sync_q[LAST][ADDR_WIDTH-2:0]};
        full_d = (wr_gray_d == full_cmp);
        wr_level_d = wr_bin_d - rd_bin_sync;
        afull_d = (wr_level_d >= AF_T);
        overflow_d = wr_en && full_q;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin_q   <= '0;
            wr_gray_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) rd_gray_sync_q[i] <= '0;
            wr_level_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= AF_RST;
            overflow_q <= 1'b0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            for (int i = 0; i < SYNC_STAGES; i++) rd_gray_sync_q[i] <= rd_gray_sync_d[i];
            wr_level_q <= wr_level_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_push) mem_q[wr_bin_q[ADDR_WIDTH-1:0]] <= wr_data;
    end

    always_comb begin
        wr_gray_sync_d[0] = wr_gray_q;
        for (int i = 1; i < SYNC_STAGES; i++) wr_gray_sync_d[i] = wr_gray_sync_q[i-1];
        wr_bin_sync = gray2bin(wr_gray_sync_q[LAST]);
`ifdef ASYNC_FIFO_V2_FWFT_EN
        // Refill the output register when it is idle or being popped.
        rd_pop = rd_en && rd_valid_q;
        rd_fetch = !arr_empty_q && (!rd_valid_q || rd_pop);
        rd_valid_d = rd_fetch || (rd_valid_q && !rd_pop);
        underflow_d = rd_en && !rd_valid_q;
`else
        rd_fetch = rd_en && !arr_empty_q;
        rd_valid_d = rd_fetch;
        underflow_d = rd_en && arr_empty_q;
`endif
        rd_bin_d = rd_bin_q + PW'(rd_fetch);
        rd_gray_d = bin2gray(rd_bin_d);
        arr_empty_d = (rd_gray_d == wr_gray_sync_q[LAST]);
        rd_data_d = rd_fetch ? mem_q[rd_bin_q[ADDR_WIDTH-1:0]] : rd_data_q;
`ifdef ASYNC_FIFO_V2_FWFT_EN
        rd_level_d = wr_bin_sync - rd_bin_d + PW'(rd_valid_d);
`else
        rd_level_d = wr_bin_sync - rd_bin_d;
`endif
        aempty_d = (rd_level_d <= AE_T);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) wr_gray_sync_q[i] <= '0;
            rd_level_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            arr_empty_q <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            for (int i = 0; i < SYNC_STAGES; i++) wr_gray_sync_q[i] <= wr_gray_sync_d[i];
            rd_level_q  <= rd_level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            arr_empty_q <= arr_empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
        end
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign wr_level     = wr_level_q;
    assign overflow     = overflow_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign almost_empty = aempty_q;
    assign rd_level     = rd_level_q;
    assign underflow    = underflow_q;
`ifdef ASYNC_FIFO_V2_FWFT_EN
    assign empty = !rd_valid_q;
`else
    assign empty = arr_empty_q;
`endif
endmodule

// File: tb/tb_async_fifo_v2.sv
// Directed-vector and scoreboard bench for async_fifo_v2 (8 bit x 16 deep).
module tb_async_fifo_v2;
    logic       wr_clk = 1'b0, rd_clk = 1'b0;
    logic       wr_rst_n, rd_rst_n;
    logic       wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       full, almost_full, overflow;
    logic       rd_valid, empty, almost_empty, underflow;
    logic [4:0] wr_level, rd_level;

    int wr_half = 5;
    int rd_half = 15;
    int pass_cnt = 0;
    int total_cnt = 0;

    always #(wr_half) wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    async_fifo_v2 #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(2),
        .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .wr_level(wr_level), .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
        .rd_level(rd_level), .underflow(underflow)
    );

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } wvec_t;

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic       valid;
        logic       empty;
        logic       aempty;
        logic [4:0] level;
    } rvec_t;

    wvec_t wv[18];
    rvec_t rv[17];
    logic [7:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wcyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic rcyc();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic write_one(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        wcyc();
        wr_en = 1'b0;
    endtask

    task automatic wait_not_empty(input string name, input int limit);
        int n;
        n = 0;
        while (empty && n < limit) begin
            rcyc();
            n++;
        end
        chk(name, empty, 0);
        chk({name, "_lat"}, (n <= limit) && (n >= 1), 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_wr_level"}, wr_level, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_rd_level"}, rd_level, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_underflow"}, underflow, 0);
    endtask

    task automatic stream(input int nwords);
        int ovf_cnt, udf_cnt, nw, nr;
        ovf_cnt = 0;
        udf_cnt = 0;
        nw = 0;
        nr = 0;
        fork
            begin
                int cyc;
                cyc = 0;
                while (nw < nwords && cyc < 20000) begin
                    wr_en = ($urandom_range(0, 3) != 0) && !full;
                    wr_data = 8'($urandom);
                    if (wr_en) begin
                        sb.push_back(wr_data);
                        nw++;
                    end
                    wcyc();
                    cyc++;
                    if (overflow) ovf_cnt++;
                end
                wr_en = 1'b0;
            end
            begin
                int cyc;
                logic [7:0] exp;
                cyc = 0;
                while (nr < nwords && cyc < 20000) begin
                    rd_en = ($urandom_range(0, 1) != 0) && !empty;
                    rcyc();
                    cyc++;
                    if (underflow) udf_cnt++;
                    if (rd_valid) begin
                        if (sb.size() == 0) begin
                            chk("stream_spurious", rd_data, 32'hffff_ffff);
                        end else begin
                            exp = sb.pop_front();
                            chk($sformatf("stream_word%0d", nr), rd_data, exp);
                        end
                        nr++;
                    end
                end
                rd_en = 1'b0;
            end
        join
        chk("stream_written", nw, nwords);
        chk("stream_read", nr, nwords);
        chk("stream_overflow", ovf_cnt, 0);
        chk("stream_underflow", udf_cnt, 0);
        chk("stream_leftover", sb.size(), 0);
    endtask

    initial begin
        wr_rst_n = 1'b0;
        rd_rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;

        for (int i = 0; i < 16; i++) begin
            wv[i] = '{1'b1, 8'(i), (i == 15), (i >= 11), 5'(i + 1), 1'b0};
        end
        wv[16] = '{1'b1, 8'hAA, 1'b1, 1'b1, 5'd16, 1'b1};
        wv[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd16, 1'b0};
        for (int k = 0; k < 16; k++) begin
            rv[k] = '{1'b1, 8'(k), 1'b1, (k == 15), ((15 - k) <= 2), 5'(15 - k)};
        end
        rv[16] = '{1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 5'd0};

        repeat (3) rcyc();
        check_reset_state("rst_hold");
        #2;
        wr_rst_n = 1'b1;
        rd_rst_n = 1'b1;
        rcyc();
        check_reset_state("rst_rel");

`ifdef ASYNC_FIFO_V2_FWFT_EN
        wcyc();
        write_one(8'h11);
        write_one(8'h22);
        wait_not_empty("fwft_first", 6);
        chk("fwft_valid0", rd_valid, 1);
        chk("fwft_data0", rd_data, 8'h11);
        repeat (4) rcyc();
        chk("fwft_hold", rd_data, 8'h11);
        chk("fwft_level", rd_level, 2);
        rd_en = 1'b1;
        rcyc();
        chk("fwft_valid1", rd_valid, 1);
        chk("fwft_data1", rd_data, 8'h22);
        rcyc();
        rd_en = 1'b0;
        chk("fwft_valid2", rd_valid, 0);
        chk("fwft_empty2", empty, 1);
        chk("fwft_level2", rd_level, 0);
`else
        wcyc();
        for (int i = 0; i < 18; i++) begin
            wr_en = wv[i].en;
            wr_data = wv[i].data;
            wcyc();
            chk($sformatf("wv%0d_level", i), wr_level, wv[i].level);
            chk($sformatf("wv%0d_full", i), full, wv[i].full);
            chk($sformatf("wv%0d_afull", i), almost_full, wv[i].afull);
            chk($sformatf("wv%0d_ovf", i), overflow, wv[i].ovf);
        end
        wr_en = 1'b0;

        repeat (4) rcyc();
        chk("pre_rd_level", rd_level, 16);
        chk("pre_rd_empty", empty, 0);
        chk("pre_rd_aempty", almost_empty, 0);
        for (int k = 0; k < 17; k++) begin
            rd_en = rv[k].en;
            rcyc();
            chk($sformatf("rv%0d_valid", k), rd_valid, rv[k].valid);
            chk($sformatf("rv%0d_data", k), rd_data, rv[k].data);
            chk($sformatf("rv%0d_empty", k), empty, rv[k].empty);
            chk($sformatf("rv%0d_aempty", k), almost_empty, rv[k].aempty);
            chk($sformatf("rv%0d_level", k), rd_level, rv[k].level);
        end
        rd_en = 1'b0;

        repeat (5) wcyc();
        chk("drain_full", full, 0);
        chk("drain_wr_level", wr_level, 0);
        chk("drain_afull", almost_full, 0);

        rd_en = 1'b1;
        rcyc();
        rd_en = 1'b0;
        chk("udf_pulse", underflow, 1);
        chk("udf_valid", rd_valid, 0);
        chk("udf_level", rd_level, 0);
        rcyc();
        chk("udf_clear", underflow, 0);
        write_one(8'h5A);
        wait_not_empty("w5a_empty", 4);
        rd_en = 1'b1;
        rcyc();
        rd_en = 1'b0;
        chk("w5a_valid", rd_valid, 1);
        chk("w5a_data", rd_data, 8'h5A);
        chk("w5a_empty", empty, 1);

        for (int i = 0; i < 9; i++) write_one(8'(8'h80 + i));
        repeat (5) rcyc();
        chk("mid_rd_level", rd_level, 9);
        chk("mid_wr_level", wr_level, 9);
        #2;
        wr_rst_n = 1'b0;
        rd_rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        repeat (2) rcyc();
        #2;
        wr_rst_n = 1'b1;
        rd_rst_n = 1'b1;
        repeat (4) rcyc();
        chk("post_rst_empty", empty, 1);
        chk("post_rst_level", rd_level, 0);
        rd_en = 1'b1;
        rcyc();
        rd_en = 1'b0;
        chk("post_rst_valid", rd_valid, 0);
        chk("post_rst_udf", underflow, 1);
        write_one(8'h77);
        wait_not_empty("post_rst_w", 4);
        rd_en = 1'b1;
        rcyc();
        rd_en = 1'b0;
        chk("post_rst_data", rd_data, 8'h77);
        chk("post_rst_valid2", rd_valid, 1);

        wcyc();
        stream(1000);
        wr_half = 15;
        rd_half = 5;
        repeat (4) wcyc();
        stream(1000);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
